// File: rtl/mmio_fifo_responder_pkg.sv
// Shared constants and helpers for the MMIO FIFO mailbox responder.
// Register offsets, STATUS bit positions and the STATUS word packer.
package mmio_fifo_responder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 26;

  localparam int OFF_DATA   = 0;
  localparam int OFF_STATUS = 1;
  localparam int OFF_CTRL   = 2;

  localparam int STS_EMPTY   = 0;
  localparam int STS_FULL    = 1;
  localparam int STS_OVF     = 2;
  localparam int STS_UNF     = 3;
  localparam int STS_CNT_LSB = 8;

  localparam int CTRL_FLUSH_BIT = 0;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  // Count arrives zero-extended to 8 bits; depths up to 2**7 fit.
  function automatic logic [DATA_WIDTH-1:0] pack_status(
    input logic       empty,
    input logic       full,
    input logic       ovf,
    input logic       unf,
    input logic [7:0] cnt
  );
    logic [DATA_WIDTH-1:0] s;
    s                   = '0;
    s[STS_EMPTY]        = empty;
    s[STS_FULL]         = full;
    s[STS_OVF]          = ovf;
    s[STS_UNF]          = unf;
    s[STS_CNT_LSB +: 8] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/mmio_fifo_responder_if.sv
// Address/strobe side of the shared memory bus plus the mailbox interrupt.
// The bidirectional data lines stay a plain inout port on the responder.
interface mmio_fifo_responder_if;
  import mmio_fifo_responder_pkg::*;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  read;
  logic                  write;
  logic                  irq;

  modport master (output addr, read, write, input irq);
  modport slave  (input addr, read, write, output irq);

endinterface

// File: rtl/mmio_fifo_responder_sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array, one synchronous write
// port and one asynchronous read port. Contents are never reset.
module sync_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo_responder.sv
// Memory-mapped FIFO mailbox: DATA pushes on store / pops on load, STATUS
// reports flow control with W1C stickies, CTRL bit0 flushes.
module mmio_fifo_responder
  import mmio_fifo_responder_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 26'h3FFFFF0,
  parameter int                    DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_fifo_responder_if.slave  bus,
  inout  wire [DATA_WIDTH-1:0]  data
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA   = BASE_ADDR + ADDR_WIDTH'(OFF_DATA);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = BASE_ADDR + ADDR_WIDTH'(OFF_STATUS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = BASE_ADDR + ADDR_WIDTH'(OFF_CTRL);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL    = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  ovf, unf, irq_q;
  logic                  read_q, write_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  reg_sel_e              reg_sel;
  logic                  selected, do_read, do_write, new_addr;
  logic                  rd_evt, wr_evt, full, empty;
  logic                  push, pop, flush, sts_wr, ovf_set, unf_set;
  logic                  rd_drive;
  logic [DATA_WIDTH-1:0] mem_rdata, rd_val;

  always_comb begin
    reg_sel = REG_NONE;
    if (bus.addr == ADDR_DATA)        reg_sel = REG_DATA;
    else if (bus.addr == ADDR_STATUS) reg_sel = REG_STATUS;
    else if (bus.addr == ADDR_CTRL)   reg_sel = REG_CTRL;
  end

  assign selected = (reg_sel != REG_NONE);
  assign do_read  = bus.read & ~bus.write;
  assign do_write = bus.write & ~bus.read;
  assign new_addr = (bus.addr != addr_q);

  // A strobe held on one address is a single access; a new address or a
  // fresh strobe starts another.
  assign rd_evt = do_read  & selected & (~read_q  | new_addr);
  assign wr_evt = do_write & selected & (~write_q | new_addr);

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  assign push    = wr_evt & (reg_sel == REG_DATA) & ~full;
  assign ovf_set = wr_evt & (reg_sel == REG_DATA) &  full;
  assign pop     = rd_evt & (reg_sel == REG_DATA) & ~empty;
  assign unf_set = rd_evt & (reg_sel == REG_DATA) &  empty;
  assign sts_wr  = wr_evt & (reg_sel == REG_STATUS);
  assign flush   = wr_evt & (reg_sel == REG_CTRL) & data[CTRL_FLUSH_BIT];

  always_comb begin
    count_nxt = count;
    if (flush)     count_nxt = '0;
    else if (push) count_nxt = count + CNT_ONE;
    else if (pop)  count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      irq_q   <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      read_q  <= bus.read;
      write_q <= bus.write;
      addr_q  <= bus.addr;
      count   <= count_nxt;
      irq_q   <= (count_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Clears first so a coincident set would win.
      if (sts_wr && data[STS_OVF]) ovf <= 1'b0;
      if (sts_wr && data[STS_UNF]) unf <= 1'b0;
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DATA:   rd_val = empty ? '0 : mem_rdata;
      REG_STATUS: rd_val = pack_status(empty, full, ovf, unf, 8'(count));
      default:    rd_val = '0;
    endcase
  end

  assign rd_drive = do_read & selected;
  assign data     = rd_drive ? rd_val : 'z;
  assign bus.irq  = irq_q;

endmodule

// File: tb/tb_mmio_fifo_responder.sv
// Directed bench for the MMIO FIFO mailbox: a vector table for single
// accesses plus hand sequences for fill/overflow, flush/wrap, held strobe, reset.
module tb_mmio_fifo_responder;
  import mmio_fifo_responder_pkg::*;

  localparam logic [25:0] BASE = 26'h3FFFFF0;
  localparam logic [25:0] A_DATA = BASE;
  localparam logic [25:0] A_STS  = BASE + 26'd1;
  localparam logic [25:0] A_CTRL = BASE + 26'd2;
  localparam logic [25:0] A_OUT  = BASE + 26'd3;

  localparam int K_IDLE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_BOTH = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [25:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_drive;
    logic        exp_irq;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        tb_oe;
  logic [31:0] tb_wdata;
  wire  [31:0] data;

  int n_checks;
  int n_fail;

  mmio_fifo_responder_if bus ();

  assign data = tb_oe ? tb_wdata : 'z;

  mmio_fifo_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts just after a rising edge; strobe for one edge, then one idle edge.
  task automatic access(input int kind, input logic [25:0] a, input logic [31:0] w,
                        output logic [31:0] rdat, output logic drv, output logic irq_after);
    bus.addr  = a;
    bus.read  = (kind == K_RD) || (kind == K_BOTH);
    bus.write = (kind == K_WR) || (kind == K_BOTH);
    tb_oe     = bus.write;
    tb_wdata  = w;
    #3;
    rdat = data;
    drv  = dut.rd_drive;
    @(posedge clk); #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    tb_oe     = 1'b0;
    irq_after = bus.irq;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [25:0] a, input logic [31:0] w);
    logic [31:0] d;
    logic        v, q;
    access(K_WR, a, w, d, v, q);
  endtask

  task automatic rd(input logic [25:0] a, output logic [31:0] d);
    logic v, q;
    access(K_RD, a, 32'h0, d, v, q);
  endtask

  function automatic vec_t mk(input string n, input int k, input logic [25:0] a,
                              input logic [31:0] w, input logic [31:0] e,
                              input logic ed, input logic ei);
    vec_t v;
    v.name = n; v.kind = k; v.addr = a; v.wdata = w;
    v.exp_data = e; v.exp_drive = ed; v.exp_irq = ei;
    return v;
  endfunction

  vec_t vecs [19];

  initial begin
    logic [31:0] got;
    logic        drv, irq_a;

    vecs[0]  = mk("idle",          K_IDLE, A_DATA, 32'h0,  32'h0,        1'b0, 1'b0);
    vecs[1]  = mk("sts_reset",     K_RD,   A_STS,  32'h0,  32'h00000001, 1'b1, 1'b0);
    vecs[2]  = mk("push1",         K_WR,   A_DATA, 32'h1,  32'h0,        1'b0, 1'b1);
    vecs[3]  = mk("push2",         K_WR,   A_DATA, 32'h2,  32'h0,        1'b0, 1'b1);
    vecs[4]  = mk("push3",         K_WR,   A_DATA, 32'h3,  32'h0,        1'b0, 1'b1);
    vecs[5]  = mk("sts_cnt3",      K_RD,   A_STS,  32'h0,  32'h00000300, 1'b1, 1'b1);
    vecs[6]  = mk("pop1",          K_RD,   A_DATA, 32'h0,  32'h1,        1'b1, 1'b1);
    vecs[7]  = mk("pop2",          K_RD,   A_DATA, 32'h0,  32'h2,        1'b1, 1'b1);
    vecs[8]  = mk("pop3",          K_RD,   A_DATA, 32'h0,  32'h3,        1'b1, 1'b0);
    vecs[9]  = mk("sts_empty",     K_RD,   A_STS,  32'h0,  32'h00000001, 1'b1, 1'b0);
    vecs[10] = mk("pop_empty",     K_RD,   A_DATA, 32'h0,  32'h0,        1'b1, 1'b0);
    vecs[11] = mk("sts_unf",       K_RD,   A_STS,  32'h0,  32'h00000009, 1'b1, 1'b0);
    vecs[12] = mk("clr_unf",       K_WR,   A_STS,  32'h8,  32'h0,        1'b0, 1'b0);
    vecs[13] = mk("sts_cleared",   K_RD,   A_STS,  32'h0,  32'h00000001, 1'b1, 1'b0);
    vecs[14] = mk("ctrl_read",     K_RD,   A_CTRL, 32'h0,  32'h0,        1'b1, 1'b0);
    vecs[15] = mk("rd_outside",    K_RD,   A_OUT,  32'h0,  32'h0,        1'b0, 1'b0);
    vecs[16] = mk("both_strobes",  K_BOTH, A_DATA, 32'h77, 32'h0,        1'b0, 1'b0);
    vecs[17] = mk("wr_outside",    K_WR,   A_OUT,  32'h99, 32'h0,        1'b0, 1'b0);
    vecs[18] = mk("sts_unchanged", K_RD,   A_STS,  32'h0,  32'h00000001, 1'b1, 1'b0);

    n_checks  = 0;
    n_fail    = 0;
    tb_oe     = 1'b0;
    tb_wdata  = '0;
    bus.addr  = A_DATA;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("irq_after_reset", {31'b0, bus.irq}, 32'h0);

    foreach (vecs[i]) begin
      access(vecs[i].kind, vecs[i].addr, vecs[i].wdata, got, drv, irq_a);
      check($sformatf("%s drive", vecs[i].name), {31'b0, drv}, {31'b0, vecs[i].exp_drive});
      if (vecs[i].exp_drive)
        check($sformatf("%s data", vecs[i].name), got, vecs[i].exp_data);
      check($sformatf("%s irq", vecs[i].name), {31'b0, irq_a}, {31'b0, vecs[i].exp_irq});
    end

    // Fill past full: 17th push dropped, overflow set.
    for (int i = 0; i < 17; i++) wr(A_DATA, 32'h00414020 + i);
    rd(A_STS, got);
    check("sts_full_ovf", got, 32'h00001006);
    check("irq_full", {31'b0, bus.irq}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      rd(A_DATA, got);
      check($sformatf("drain[%0d]", i), got, 32'h00414020 + i);
    end
    rd(A_STS, got);
    check("sts_drained_ovf", got, 32'h00000005);

    // Flush leaves the overflow sticky alone.
    for (int i = 0; i < 5; i++) wr(A_DATA, 32'h50 + i);
    wr(A_CTRL, 32'h1);
    rd(A_STS, got);
    check("sts_after_flush", got, 32'h00000005);
    check("irq_after_flush", {31'b0, bus.irq}, 32'h0);
    wr(A_STS, 32'hC);
    rd(A_STS, got);
    check("sts_w1c_both", got, 32'h00000001);
    wr(A_DATA, 32'hA5);
    rd(A_DATA, got);
    check("push_pop_a5", got, 32'h000000A5);
    for (int i = 0; i < 20; i++) begin
      wr(A_DATA, 32'h1000 + i);
      rd(A_DATA, got);
      check($sformatf("wrap[%0d]", i), got, 32'h1000 + i);
    end
    rd(A_STS, got);
    check("sts_after_wrap", got, 32'h00000001);

    // Held read strobe pops once.
    wr(A_DATA, 32'h11);
    wr(A_DATA, 32'h22);
    bus.addr = A_DATA;
    bus.read = 1'b1;
    #3;
    got = data;
    check("held_read_head", got, 32'h11);
    repeat (3) @(posedge clk);
    #1;
    bus.read = 1'b0;
    @(posedge clk); #1;
    rd(A_STS, got);
    check("held_read_count", got, 32'h00000100);
    rd(A_DATA, got);
    check("held_read_next", got, 32'h22);

    // Reset with entries and a sticky pending.
    rd(A_DATA, got);
    wr(A_DATA, 32'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("irq_mid_reset", {31'b0, bus.irq}, 32'h0);
    rd(A_STS, got);
    check("sts_after_reset", got, 32'h00000001);
    wr(A_DATA, 32'h44);
    rd(A_DATA, got);
    check("first_after_reset", got, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
